// File: rtl/dct_sum_scale_pipe.sv
// dct_sum_scale_pipe
//   Pipelined signed adder tree with scaling. NUM_IN signed lanes are summed
//   over L = log2(NUM_IN) registered tree levels. A final registered stage
//   divides the sum by 2^SHIFT (truncate toward zero or round half away from
//   zero), then saturates or wraps to OUT_W bits. Latency is L+1 cycles and
//   throughput is one vector per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   input vector valid
//   in_data    packed signed lanes, lane k at [k*IN_W +: IN_W]
//   rnd_mode   0 = truncate toward zero, 1 = round half away from zero
//   sat_en     1 = saturate to OUT_W, 0 = keep low OUT_W bits
//   out_valid  out_data/out_ovf valid
//   out_data   signed scaled sum
//   out_ovf    scaled result was outside the OUT_W signed range
module dct_sum_scale_pipe #(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned IN_W   = 14,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned SHIFT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    input  logic                     rnd_mode,
    input  logic                     sat_en,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_ovf
);

    localparam int unsigned L  = $clog2(NUM_IN);
    localparam int unsigned SW = IN_W + L;
    // Result width: wide enough for -|S| and +|S| and for the OUT_W limits.
    localparam int unsigned RW = (SW + 2 > OUT_W + 1) ? SW + 2 : OUT_W + 1;

    localparam int unsigned HALF_SH = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic [SW:0] HALF    = (SHIFT == 0) ? '0 : ((SW + 1)'(1) << HALF_SH);

    localparam logic signed [RW-1:0] MAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] MIN = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Adder tree: level gl holds NUM_IN >> (gl+1) partial sums of IN_W+gl+1 bits.
    for (genvar gl = 0; gl < L; gl++) begin : g_lvl
        localparam int unsigned W = IN_W + gl + 1;
        localparam int unsigned N = NUM_IN >> (gl + 1);

        logic [W-2:0] op [2*N];
        logic         prv_vld;
        logic         prv_rnd;
        logic         prv_sat;
        logic [W-1:0] sum_q [N];
        logic         vld_q;
        logic         rnd_q;
        logic         sat_q;

        if (gl == 0) begin : g_src
            always_comb begin
                for (int unsigned k = 0; k < 2 * N; k++) begin
                    op[k] = in_data[k*IN_W +: IN_W];
                end
            end
            assign prv_vld = in_valid;
            assign prv_rnd = rnd_mode;
            assign prv_sat = sat_en;
        end else begin : g_src
            always_comb begin
                for (int unsigned k = 0; k < 2 * N; k++) begin
                    op[k] = g_lvl[gl-1].sum_q[k];
                end
            end
            assign prv_vld = g_lvl[gl-1].vld_q;
            assign prv_rnd = g_lvl[gl-1].rnd_q;
            assign prv_sat = g_lvl[gl-1].sat_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= prv_vld;
            end
        end

        // Data and modes only load with a valid vector; one extra sign bit
        // per level makes the add overflow-free.
        always_ff @(posedge clk) begin
            if (prv_vld) begin
                rnd_q <= prv_rnd;
                sat_q <= prv_sat;
                for (int unsigned k = 0; k < N; k++) begin
                    sum_q[k] <= {op[2*k][W-2], op[2*k]} + {op[2*k+1][W-2], op[2*k+1]};
                end
            end
        end
    end

    logic [SW-1:0]          s;
    logic                   fin_vld;
    logic                   fin_rnd;
    logic                   fin_sat;
    logic                   s_neg;
    logic [SW:0]            mag;
    logic [SW:0]            q;
    logic signed [RW-1:0]   r;
    logic                   ovf;
    logic [OUT_W-1:0]       res;

    assign s       = g_lvl[L-1].sum_q[0];
    assign fin_vld = g_lvl[L-1].vld_q;
    assign fin_rnd = g_lvl[L-1].rnd_q;
    assign fin_sat = g_lvl[L-1].sat_q;

    always_comb begin
        s_neg = s[SW-1];
        // One extra bit so |most negative sum| is representable.
        mag   = s_neg ? -{1'b1, s} : {1'b0, s};
        q     = (mag + (fin_rnd ? HALF : '0)) >> SHIFT;
        // Sign applied after scaling, so a zero magnitude never turns into -1.
        r     = s_neg ? -RW'(q) : RW'(q);
        ovf   = (r > MAX) || (r < MIN);
        res   = r[OUT_W-1:0];
        if (fin_sat && ovf) begin
            res = r[RW-1] ? MIN[OUT_W-1:0] : MAX[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                out_data <= res;
                out_ovf  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_dct_sum_scale_pipe.sv
// Self-checking bench for dct_sum_scale_pipe: default configuration checked
// cycle by cycle against an arithmetic reference model with an expectation
// queue, plus a NUM_IN=4 / SHIFT=0 instance checked with directed vectors.
module tb_dct_sum_scale_pipe;

    localparam int NUM_IN = 8;
    localparam int IN_W   = 14;
    localparam int OUT_W  = 12;
    localparam int SHIFT  = 3;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   in_valid;
    logic [NUM_IN*IN_W-1:0] in_data;
    logic                   rnd_mode;
    logic                   sat_en;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic                   out_ovf;

    logic        b_rst;
    logic        b_in_valid;
    logic [39:0] b_in_data;
    logic        b_rnd_mode;
    logic        b_sat_en;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic        b_out_ovf;

    dct_sum_scale_pipe #(
        .NUM_IN (NUM_IN),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rnd_mode  (rnd_mode),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    dct_sum_scale_pipe #(
        .NUM_IN (4),
        .IN_W   (10),
        .OUT_W  (8),
        .SHIFT  (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .rnd_mode  (b_rnd_mode),
        .sat_en    (b_sat_en),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf)
    );

    typedef struct {
        int     due;
        longint d;
        bit     o;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc;
    int     n_checks;
    int     n_err;
    longint last_d;
    bit     last_o;
    int     lanes[NUM_IN];

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference: divide |S| by 2^shift, re-apply sign, then clamp or wrap.
    function automatic void model(input longint s, input int shift, input int outw,
                                  input bit rnd, input bit sat,
                                  output longint data, output bit ovf);
        longint m, q, r, mx, mn;
        m = (s < 0) ? -s : s;
        if (rnd && shift > 0) q = (m + (longint'(1) << (shift - 1))) >> shift;
        else                  q = m >> shift;
        r   = (s < 0) ? -q : q;
        mx  = (longint'(1) << (outw - 1)) - 1;
        mn  = -mx - 1;
        ovf = (r > mx) || (r < mn);
        if (sat) begin
            data = ovf ? ((r > mx) ? mx : mn) : r;
        end else begin
            data = r & ((longint'(1) << outw) - 1);
            if (data > mx) data = data - (longint'(1) << outw);
        end
    endfunction

    // One cycle: check outputs at the falling edge, then drive the next inputs.
    task automatic step(input bit v, input bit rn, input bit st, input bit r);
        exp_t   e;
        longint s;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("out_valid", out_valid, 1);
            check("out_data", $signed(out_data), e.d);
            check("out_ovf", out_ovf, e.o);
            last_d = e.d;
            last_o = e.o;
        end else begin
            check("out_valid_idle", out_valid, 0);
            check("out_data_hold", $signed(out_data), last_d);
            check("out_ovf_hold", out_ovf, last_o);
        end
        rst      = r;
        in_valid = v;
        rnd_mode = rn;
        sat_en   = st;
        for (int k = 0; k < NUM_IN; k++) in_data[k*IN_W +: IN_W] = lanes[k][IN_W-1:0];
        if (r) begin
            exp_q.delete();
            last_d = 0;
            last_o = 1'b0;
        end else if (v) begin
            s = 0;
            for (int k = 0; k < NUM_IN; k++) s += lanes[k];
            model(s, SHIFT, OUT_W, rn, st, e.d, e.o);
            e.due = cyc + LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NUM_IN; k++) lanes[k] = v;
    endtask

    task automatic set_lane0(input int v);
        set_all(0);
        lanes[0] = v;
    endtask

    task automatic rand_lanes();
        int sel;
        for (int k = 0; k < NUM_IN; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      lanes[k] = -8192;
            else if (sel == 1) lanes[k] = 8191;
            else               lanes[k] = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    task automatic run1(input bit rn, input bit st);
        step(1'b1, rn, st, 1'b0);
        repeat (LAT + 1) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    bit [9:0] pat;
    int       vi;

    initial begin
        n_checks   = 0;
        n_err      = 0;
        cyc        = 0;
        last_d     = 0;
        last_o     = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        rnd_mode   = 1'b0;
        sat_en     = 1'b0;
        b_rst      = 1'b1;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_rnd_mode = 1'b0;
        b_sat_en   = 1'b0;
        set_all(0);
        repeat (3) @(negedge clk);

        // Directed magnitude/sign cases
        set_all(100);   run1(1'b0, 1'b1);
        set_lane0(-7);  run1(1'b0, 1'b0);
        set_lane0(-7);  run1(1'b1, 1'b0);
        set_lane0(12);  run1(1'b0, 1'b1);
        set_lane0(12);  run1(1'b1, 1'b1);
        set_lane0(-12); run1(1'b0, 1'b1);
        set_lane0(-12); run1(1'b1, 1'b1);
        set_lane0(4);   run1(1'b1, 1'b0);
        set_lane0(-4);  run1(1'b1, 1'b0);

        // Saturation and wrap at the lane extremes
        set_all(8191);  run1(1'b0, 1'b1);
        set_all(8191);  run1(1'b0, 1'b0);
        set_all(-8192); run1(1'b0, 1'b1);
        set_all(-8192); run1(1'b0, 1'b0);
        set_all(-8192); run1(1'b1, 1'b0);

        // Streaming with gaps and per-vector modes
        pat = 10'b1101101111;
        vi  = 0;
        for (int i = 0; i < 10; i++) begin
            rand_lanes();
            if (pat[9-i]) begin
                step(1'b1, vi[0], vi[1], 1'b0);
                vi++;
            end else begin
                step(1'b0, 1'b1, 1'b1, 1'b0);
            end
        end
        repeat (LAT + 1) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            rand_lanes();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (LAT + 1) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with three vectors in flight; in_valid during reset is ignored
        for (int i = 0; i < 3; i++) begin
            rand_lanes();
            step(1'b1, 1'(i), 1'b0, 1'b0);
        end
        set_all(500);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        set_all(-300);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (LAT + 2) step(1'b0, 1'b0, 1'b0, 1'b0);

        // NUM_IN=4, IN_W=10, OUT_W=8, SHIFT=0 instance
        check("b_reset_valid", b_out_valid, 0);
        check("b_reset_data", $signed(b_out_data), 0);
        check("b_reset_ovf", b_out_ovf, 0);
        b_rst = 1'b0;
        @(negedge clk);
        b_in_data  = {10'h3CE, 10'd100, 10'd100, 10'd100};
        b_in_valid = 1'b1;
        b_sat_en   = 1'b1;
        b_rnd_mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("b_out_valid", b_out_valid, (i == 3 || i == 4) ? 1 : 0);
            if (i == 3) begin
                check("b_sat_data", $signed(b_out_data), 127);
                check("b_sat_ovf", b_out_ovf, 1);
            end
            if (i == 4) begin
                check("b_wrap_data", $signed(b_out_data), -6);
                check("b_wrap_ovf", b_out_ovf, 1);
            end
            if (i == 1) begin
                b_sat_en   = 1'b0;
                b_rnd_mode = 1'b1;
            end
            if (i == 2) b_in_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
